// File: rtl/half_word_sched_pkg.sv
// Shared types and constants for the half-word scheduler.
package half_word_sched_pkg;

  // Default byte width; a word is two bytes.
  localparam int BYTE_W_DEF = 8;

  // Width of the source tag carried with each byte.
  localparam int SRC_W = 1;

  // IDLE holds nothing, FIRST presents the first byte, SECOND the final byte.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. The priority pointer is owned by the caller.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic prio,
  output logic grant,
  output logic grant_valid
);

  // A tie goes to the favoured requester; a lone requester always wins.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    grant       = 1'b0;
    grant_valid = valid0 | valid1;
    if (valid0 && valid1) begin
      grant = prio;
    end else if (valid1) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/half_word_sched.sv
// Two-requester word scheduler that emits each granted word as two tagged bytes.
// Build option: define HWS_LO_FIRST_EN to emit the low byte first.
module half_word_sched
  import half_word_sched_pkg::*;
#(
  parameter int BYTE_W = BYTE_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req0_valid,
  input  logic [2*BYTE_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [2*BYTE_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_byte,
  output logic              out_src,
  output logic              out_last,
  output logic              busy
);

  state_t              state;
  state_t              state_nx;
  logic [2*BYTE_W-1:0] word_q;
  logic [SRC_W-1:0]    src_q;
  logic                prio;
  logic                slot;
  logic                grant;
  logic                grant_valid;
  logic                accept;
  logic [BYTE_W-1:0]   first_byte;
  logic [BYTE_W-1:0]   second_byte;

  // A new word can be taken when nothing is held, or as the final byte leaves.
  // Reset masks the slot so no requester sees ready while resetn is low.
  assign slot = resetn & ((state == IDLE) | ((state == SECOND) & out_ready));

  rr_arb2 u_arb (
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .prio        (prio),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  assign accept     = slot & grant_valid;
  assign req0_ready = accept & ~grant;
  assign req1_ready = accept & grant;
  assign busy       = (state != IDLE);

`ifdef HWS_LO_FIRST_EN
  assign first_byte  = word_q[BYTE_W-1:0];
  assign second_byte = word_q[2*BYTE_W-1:BYTE_W];
`else
  assign first_byte  = word_q[2*BYTE_W-1:BYTE_W];
  assign second_byte = word_q[BYTE_W-1:0];
`endif

  // Next-state: advance on consumer handshake, chain straight into a new word.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = FIRST;
      FIRST:   if (out_ready) state_nx = SECOND;
      SECOND:  if (out_ready) state_nx = accept ? FIRST : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, held word, source tag and priority pointer; reset discards any held word.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!resetn) begin
      state  <= IDLE;
      word_q <= '0;
      src_q  <= '0;
      prio   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        word_q <= grant ? req1_data : req0_data;
        src_q  <= grant;
        prio   <= ~grant;
      end
    end
  end

  // Byte-stream outputs depend only on registered state, so they hold during a stall.
  always_comb begin
    out_valid = 1'b0;
    out_byte  = '0;
    out_src   = 1'b0;
    out_last  = 1'b0;
    unique case (state)
      FIRST: begin
        out_valid = 1'b1;
        out_byte  = first_byte;
        out_src   = src_q;
      end
      SECOND: begin
        out_valid = 1'b1;
        out_byte  = second_byte;
        out_src   = src_q;
        out_last  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
